serial_tx: RTL
==============

# serial_tx

Framed serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line.
- Frame: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
- Each bit is held for DIV clock cycles.
- It is the transmit end of the single-wire serial link; the matching receiver samples the same frame format.

## Interface
Parameters:
- WIDTH, 8, data bits per frame (>= 1)
- DIV, 4, clock cycles per bit (>= 1)
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd

Ports:
- clk  input  1  clock; all state changes on posedge clk
- rst  input  1  reset; synchronous, active-high, highest priority
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word; equals (state == IDLE) & ~rst
- tx_data  input  WIDTH  word to send; sampled only on handshake
- txd  output  1  serial line, registered; idles high
- busy  output  1  registered; high from the cycle after the handshake through the last stop-bit cycle

## Operation
- The handshake occurs on any posedge where tx_valid & tx_ready are both high.
  - tx_data is captured into the shift register.
  - The parity bit is computed from the captured word:
    - even: XOR of all bits.
    - odd: inverted XOR of all bits.
  - The state moves IDLE -> START.
- States:
  - IDLE: txd = 1, busy = 0.
  - START: txd = 0.
  - DATA: txd = shreg[0]; shift right on each bit boundary. A bit index counter runs 0..WIDTH-1.
  - PAR: txd = parity bit. Skipped when PARITY = 0.
  - STOP: txd = 1.
- Transitions:
  - START -> DATA after DIV cycles.
  - DATA -> PAR (PARITY != 0) or STOP (PARITY = 0) after WIDTH*DIV cycles.
  - PAR -> STOP after DIV cycles.
  - STOP -> IDLE after DIV cycles.
- Bit timer: counts 0..DIV-1 and reloads to 0 at each bit boundary. Width is clog2(DIV), minimum 1. With DIV = 1 every cycle is a boundary.
- While busy, tx_valid and tx_data are ignored. Changes to tx_data have no effect on the frame in flight.
- PARITY values other than 0/1/2 are treated as 0.

## Timing
- Reset: rst sampled high at a posedge forces the following, regardless of current state:
  - state = IDLE, txd = 1, busy = 0, timer = 0, bit index = 0, shift register = 0.
- tx_ready is 0 in any cycle where rst is high. No handshake can occur during reset.
- Reset asserted mid-frame aborts the frame. txd is 1 from the first posedge with rst high; no partial stop bit is added.
- Latency: handshake at posedge N → txd = 0 and busy = 1 from posedge N+1.
- Frame length: F = (WIDTH + 2 + (PARITY != 0)) * DIV cycles.
  - txd carries frame bit k during cycles N+1+k*DIV .. N+(k+1)*DIV.
  - busy is high for exactly F cycles.
- Back-to-back: the last stop-bit cycle ends at posedge N+F, where state -> IDLE. tx_ready rises combinationally in that cycle.
  - If tx_valid is held high, the next handshake is at posedge N+F+1.
  - The next start bit appears at N+F+2, so there is one idle-high cycle between frames.
- Simultaneous rst and tx_valid: rst wins, nothing is captured.

## Test plan
- WIDTH=8, DIV=4, PARITY=0; send 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. busy high exactly 40 cycles. tx_ready low for those 40 cycles.
- PARITY=1 send 0x07 → parity bit 1. PARITY=2 send 0x07 → parity bit 0. Frame is 44 cycles. Stop bit follows the parity bit.
- tx_valid held high with words 0x01 then 0xFF → two complete frames separated by exactly one idle-high cycle. Second frame bits are all 1 after its start bit.
- During a frame, toggle tx_valid and change tx_data to 0x00 every cycle → transmitted bits unchanged. No second frame until tx_ready is high.
- Assert rst for 1 cycle at cycle 17 of a 0x55 frame → txd = 1, busy = 0 from that posedge. Next handshake produces a clean full frame.
- DIV=1, WIDTH=4, PARITY=0; send 0xC → txd = 0,0,0,1,1,1 on consecutive cycles. busy high exactly 6 cycles.

Source files
------------

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit; each bit held for DIV clock cycles.
module serial_tx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             txd,
  output logic             busy
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit HASP = (PARITY == 1) || (PARITY == 2);
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [IW-1:0]    bidx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt;
  logic             pbit;
  logic             tick;

  assign tx_ready = (state == IDLE) & ~rst;
  assign tick     = (tmr == TMAX);
  assign nxt      = shreg >> 1;

  // txd is registered together with the state, so it always
  // reflects the bit of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      bidx  <= '0;
      shreg <= '0;
      pbit  <= 1'b0;
      txd   <= 1'b1;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tmr <= '0;
          if (tx_valid) begin
            shreg <= tx_data;
            pbit  <= (PARITY == 2) ? ~^tx_data : ^tx_data;
            state <= START;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            tmr   <= '0;
            bidx  <= '0;
            state <= DATA;
            txd   <= shreg[0];
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            tmr <= '0;
            if (bidx == IMAX) begin
              state <= HASP ? PAR : STOP;
              txd   <= HASP ? pbit : 1'b1;
            end else begin
              bidx  <= bidx + 1'b1;
              shreg <= nxt;
              txd   <= nxt[0];
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        PAR: begin
          if (tick) begin
            tmr   <= '0;
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            tmr   <= '0;
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
